// File: rtl/pipe_addsub.sv
// pipe_addsub: pipelined ripple-carry adder/subtractor.
// The operand is split into STAGES chunks of CW bits; stage k ripples chunk k
// using the carry registered by stage k-1. Upper operand chunks ride along in
// skew registers and finished lower sum chunks ride along in deskew registers,
// so the full result leaves the last stage aligned. A single global advance
// enable stalls every stage at once when the output is blocked.
// WIDTH must be a multiple of STAGES.
module pipe_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = WIDTH / STAGES;

  // Inputs seen by each stage: operands (b already inverted for subtract),
  // partially built sum, incoming chunk carry and valid.
  logic [STAGES-1:0][WIDTH-1:0] ai, bi, si;
  logic [STAGES-1:0]            ci, vi;

  logic             adv;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q, out_valid_q;

  // Whole pipeline moves together unless a finished result is blocked.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  // Subtract is a + ~b + !cin: fold the inversion and carry flip in up front
  // so every stage is a plain adder and the mode never travels down the pipe.
  assign ai[0] = a;
  assign bi[0] = b ^ {WIDTH{sub}};
  assign si[0] = '0;
  assign ci[0] = cin ^ sub;
  assign vi[0] = in_valid;

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  // Ripple of full-adder cells over chunk k; other bits of s pass through.
  // Returns {carry out of the chunk, updated sum word}.
  function automatic logic [WIDTH:0] chunk_add(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic [WIDTH-1:0] s,
    input logic             c,
    input int               k
  );
    logic [WIDTH-1:0] so;
    logic             cy;
    so = s;
    cy = c;
    for (int i = 0; i < CW; i++) begin
      so[k*CW+i] = x[k*CW+i] ^ y[k*CW+i] ^ cy;
      cy         = (x[k*CW+i] & y[k*CW+i]) | (cy & (x[k*CW+i] ^ y[k*CW+i]));
    end
    return {cy, so};
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic [WIDTH:0] res_d;
    assign res_d = chunk_add(ai[k], bi[k], si[k], ci[k], k);

    if (k < STAGES-1) begin : g_mid
      logic [WIDTH-1:0] a_q, b_q, s_q;
      logic             c_q, v_q;

      // Intermediate stage: register chunk carry, partial sum and skewed operands.
      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= 1'b0;
          c_q <= 1'b0;
          a_q <= '0;
          b_q <= '0;
          s_q <= '0;
        end else if (adv) begin
          v_q <= vi[k];
          c_q <= res_d[WIDTH];
          a_q <= ai[k];
          b_q <= bi[k];
          s_q <= res_d[WIDTH-1:0];
        end
      end

      assign ai[k+1] = a_q;
      assign bi[k+1] = b_q;
      assign si[k+1] = s_q;
      assign ci[k+1] = c_q;
      assign vi[k+1] = v_q;
    end else begin : g_last
      logic c_msb_in;
      // Carry into the MSB recovered from the MSB cell's inputs and output.
      assign c_msb_in = ai[k][WIDTH-1] ^ bi[k][WIDTH-1] ^ res_d[WIDTH-1];

      // Final stage: register the aligned result, carry-out and overflow.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid_q <= 1'b0;
          sum_q       <= '0;
          cout_q      <= 1'b0;
          ovf_q       <= 1'b0;
        end else if (adv) begin
          out_valid_q <= vi[k];
          sum_q       <= res_d[WIDTH-1:0];
          cout_q      <= res_d[WIDTH];
          ovf_q       <= c_msb_in ^ res_d[WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_addsub.sv
// tb_pipe_addsub: directed and random stimulus for pipe_addsub (16 bits, 4
// stages) checked against an arithmetic reference model and a queue of
// expected results tagged with the advance count at acceptance.
module tb_pipe_addsub;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b;
  logic         cin, sub;
  logic         out_valid, out_ready;
  logic [W-1:0] sum;
  logic         cout, ovf;

  pipe_addsub #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           t;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           failures = 0;
  int           adv_cnt = 0;
  int           n_out = 0;
  logic         acc;
  logic [W-1:0] last_s;
  logic         last_c, last_o;

  // Reference: plain unsigned arithmetic for sum/carry, signed range test for overflow.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sb, input int t);
    exp_t        e;
    logic [W:0]  u;
    int          sx, sy, r;
    sx = $signed(x);
    sy = $signed(y);
    if (!sb) begin
      u = {1'b0, x} + {1'b0, y} + {16'd0, ci};
      r = sx + sy + int'(ci);
    end else begin
      u = {1'b0, x} + 17'h10000 - {1'b0, y} - {16'd0, ci};
      r = sx - sy - int'(ci);
    end
    e.s = u[W-1:0];
    e.c = u[W];
    e.o = (r > 32767) || (r < -32768);
    e.t = t;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs and update the model at the falling edge.
  task automatic tick();
    logic exp_ov;
    @(negedge clk);
    acc = 1'b0;
    if (rst) begin
      q.delete();
    end else begin
      exp_ov = (q.size() > 0) && (adv_cnt == q[0].t + S);
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
      chk("in_ready", {31'd0, in_ready}, {31'd0, (!exp_ov || out_ready)});
      if (out_valid && exp_ov) begin
        chk("sum", {16'd0, sum}, {16'd0, q[0].s});
        chk("cout", {31'd0, cout}, {31'd0, q[0].c});
        chk("ovf", {31'd0, ovf}, {31'd0, q[0].o});
      end
      if (out_valid && out_ready) begin
        last_s = sum; last_c = cout; last_o = ovf;
        n_out++;
        if (q.size() > 0) void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, cin, sub, adv_cnt));
        acc = 1'b1;
      end
      if (in_ready) adv_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (q.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain_timeout", {31'd0, (q.size() > 0)}, 32'd0);
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic ci, input logic sb);
    a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    drain();
  endtask

  task automatic chk_last(input string tag, input logic [W-1:0] s,
                          input logic c, input logic o);
    chk({tag, "_sum"}, {16'd0, last_s}, {16'd0, s});
    chk({tag, "_cout"}, {31'd0, last_c}, {31'd0, c});
    chk({tag, "_ovf"}, {31'd0, last_o}, {31'd0, o});
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_sum"}, {16'd0, sum}, 32'd0);
    chk({tag, "_cout"}, {31'd0, cout}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int i, n, n0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk_reset("reset");

    // Directed arithmetic cases.
    send(16'h0FFF, 16'h0001, 1'b0, 1'b0);
    chk_last("ripple", 16'h1000, 1'b0, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    chk_last("wrap", 16'h0000, 1'b1, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    chk_last("addovf", 16'h8000, 1'b0, 1'b1);
    send(16'h0005, 16'h0007, 1'b0, 1'b1);
    chk_last("borrow", 16'hFFFE, 1'b0, 1'b0);
    send(16'h8000, 16'h0001, 1'b1, 1'b1);
    chk_last("subovf", 16'h7FFE, 1'b1, 1'b1);

    // Streaming: 8 back-to-back random operations.
    n0 = n_out;
    for (int k = 0; k < 8; k++) begin
      a = W'($urandom); b = W'($urandom);
      cin = 1'($urandom); sub = 1'($urandom); in_valid = 1'b1;
      tick();
    end
    drain();
    chk("stream_count", n_out - n0, 32'd8);

    // Backpressure: 6 ops, out_ready low for 5 cycles mid-stream.
    n0 = n_out;
    i = 0; n = 0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    while (i < 6 && n < 100) begin
      in_valid = 1'b1;
      out_ready = !(n >= 3 && n < 8);
      tick();
      if (acc) begin
        i++;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      end
      n++;
    end
    out_ready = 1'b1;
    drain();
    chk("bp_count", n_out - n0, 32'd6);

    // Random valid/ready traffic.
    for (int k = 0; k < 200; k++) begin
      if (!in_valid || acc) begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    out_ready = 1'b1;
    drain();

    // Reset mid-flight, with an input offered during reset.
    for (int k = 0; k < 3; k++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      tick();
    end
    rst = 1'b1;
    a = 16'h1111; b = 16'h2222;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk_reset("midreset");
    n0 = n_out;
    for (int k = 0; k < 8; k++) tick();
    chk("no_stale", n_out - n0, 32'd0);
    send(16'h1234, 16'h4321, 1'b0, 1'b0);
    chk_last("postreset", 16'h5555, 1'b0, 1'b0);
    chk("postreset_count", n_out - n0, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
